// File: rtl/eth_pkg.sv
// eth_pkg
// Shared constants and types for the GMII receive path.
//   - Preamble / SFD byte values seen on the GMII stream.
//   - CRC-32 polynomial, init value and good-frame residue.
//   - Delay-line depth used to strip the trailing FCS.
//   - Receive FSM state enum.
//   - reflect32() helper to derive the LSB-first polynomial form.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Four FCS bytes plus the byte being released: holding five bytes lets
  // the last payload byte be tagged as end-of-frame when dv drops.
  localparam int PIPE_DEPTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  // Bit-reverse a 32-bit word; turns the normal-form polynomial into the
  // form used by an LSB-first shift register.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Ports:
//   i_crc  [31:0] current CRC register (LSB-first)
//   i_data [7:0]  data byte, consumed LSB first
//   o_crc  [31:0] CRC register after absorbing i_data
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  // Eight unrolled shift steps; each data bit is XORed into the feedback
  // at the register LSB, matching the on-wire bit order of GMII bytes.
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (o_crc[0] ^ i_data[i]) begin
        o_crc = (o_crc >> 1) ^ POLY_REFL;
      end else begin
        o_crc = o_crc >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame
// Receive-side frame delineator on the GMII byte stream. Finds the
// preamble/SFD, releases the post-SFD payload with the 4-byte FCS
// removed (sof/eof framed) and emits one status word per frame.
// Optional feature macro: GMII_RX_CRC_EN builds the CRC-32 checker;
// without it stat_crc_err is tied to 0.
// Ports:
//   gmii_rx_clk  receive clock, rising edge
//   rst_n        asynchronous active-low reset
//   gmii_rx_dv   GMII data valid
//   gmii_rxd     GMII data byte
//   out_data     payload byte
//   out_valid    out_data valid this cycle
//   out_sof      first payload byte of a frame
//   out_eof      last payload byte of a frame
//   stat_valid   one-cycle status strobe per frame
//   stat_len     payload length (raw post-SFD count for runts), saturating
//   stat_runt    fewer than 5 post-SFD bytes
//   stat_crc_err FCS check failed
module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             stat_valid,
  output logic [LEN_W-1:0] stat_len,
  output logic             stat_runt,
  output logic             stat_crc_err
);

  localparam logic [2:0] PIPE_FULL = 3'(PIPE_DEPTH);

  rx_state_e        r_state;
  rx_state_e        w_stateNext;
  logic             w_sfdSeen;
  logic             w_byteIn;
  logic             w_endFrame;

  logic [7:0]       r_pipe [PIPE_DEPTH];
  logic [2:0]       r_fill;
  logic [LEN_W-1:0] r_cnt;
  logic             r_sofPending;
  logic             w_pipeFull;
  logic [LEN_W-1:0] w_payLen;
  logic             w_crcErr;

  // FSM state register.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode plus the three datapath strobes: SFD accepted,
  // payload byte accepted, and end of a delineated frame.
  always_comb begin
    w_stateNext = r_state;
    w_sfdSeen   = 1'b0;
    w_byteIn    = 1'b0;
    w_endFrame  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          w_stateNext = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          w_stateNext = ST_IDLE;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          w_stateNext = ST_PREAMBLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          w_stateNext = ST_DATA;
          w_sfdSeen   = 1'b1;
        end else begin
          w_stateNext = ST_DROP;
        end
      end
      ST_DATA: begin
        if (gmii_rx_dv) begin
          w_byteIn = 1'b1;
        end else begin
          w_stateNext = ST_IDLE;
          w_endFrame  = 1'b1;
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign w_pipeFull = (r_fill == PIPE_FULL);
  // A saturated counter keeps reporting all-ones rather than wrapping back.
  assign w_payLen   = (r_cnt == '1) ? '1 : (r_cnt - LEN_W'(4));

`ifdef GMII_RX_CRC_EN
  logic [31:0] r_crc;
  logic [31:0] w_crcNext;

  crc32_d8 u_crc32 (
    .i_crc  (r_crc),
    .i_data (gmii_rxd),
    .o_crc  (w_crcNext)
  );

  // Running CRC over every post-SFD byte, FCS included, so a good frame
  // leaves the fixed residue in the register.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (w_sfdSeen) begin
      r_crc <= CRC_INIT;
    end else if (w_byteIn) begin
      r_crc <= w_crcNext;
    end
  end

  assign w_crcErr = (r_crc != CRC_RESIDUE);
`else
  assign w_crcErr = 1'b0;
`endif

  // Delay line, counters and registered outputs. The oldest byte is
  // released only once five newer bytes exist, so the FCS never leaves.
  // At end of frame the oldest entry is the final payload byte.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
      r_fill       <= '0;
      r_cnt        <= '0;
      r_sofPending <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      stat_valid   <= 1'b0;
      stat_len     <= '0;
      stat_runt    <= 1'b0;
      stat_crc_err <= 1'b0;
    end else begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      stat_valid   <= 1'b0;
      stat_len     <= '0;
      stat_runt    <= 1'b0;
      stat_crc_err <= 1'b0;

      if (w_sfdSeen) begin
        r_fill       <= '0;
        r_cnt        <= '0;
        r_sofPending <= 1'b1;
      end

      if (w_byteIn) begin
        r_pipe[0] <= gmii_rxd;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + LEN_W'(1);
        end
        if (!w_pipeFull) begin
          r_fill <= r_fill + 3'd1;
        end else begin
          out_valid    <= 1'b1;
          out_data     <= r_pipe[PIPE_DEPTH-1];
          out_sof      <= r_sofPending;
          r_sofPending <= 1'b0;
        end
      end

      if (w_endFrame) begin
        stat_valid <= 1'b1;
        if (w_pipeFull) begin
          out_valid    <= 1'b1;
          out_data     <= r_pipe[PIPE_DEPTH-1];
          out_sof      <= r_sofPending;
          out_eof      <= 1'b1;
          r_sofPending <= 1'b0;
          stat_len     <= w_payLen;
          stat_crc_err <= w_crcErr;
        end else begin
          stat_len  <= r_cnt;
          stat_runt <= 1'b1;
        end
      end
    end
  end

endmodule
